// File: rtl/scarv_cop_pkg.sv
// -----------------------------------------------------------------------------
// scarv_cop_pkg
//   Shared widths, defaults and the buffered-entry type for the COP
//   instruction intake path.
//
//   SCARV_COP_INSN_W        instruction encoding width
//   SCARV_COP_XLEN          GPR width of the captured rs1 operand
//   SCARV_COP_IFIFO_DEPTH   default intake FIFO depth
//   SCARV_COP_MAX_INFLIGHT  default dispatch window
//   SCARV_COP_INFLIGHT_W    width of the in-flight counter (holds up to 15)
// -----------------------------------------------------------------------------
package scarv_cop_pkg;

  localparam int SCARV_COP_INSN_W       = 32;
  localparam int SCARV_COP_XLEN         = 32;
  localparam int SCARV_COP_IFIFO_DEPTH  = 4;
  localparam int SCARV_COP_MAX_INFLIGHT = 2;
  localparam int SCARV_COP_INFLIGHT_W   = 4;

  typedef struct packed {
    logic [SCARV_COP_INSN_W-1:0] enc;
    logic [SCARV_COP_XLEN-1:0]   rs1;
  } scarv_cop_entry_t;

  function automatic scarv_cop_entry_t scarv_cop_mk_entry(
    input logic [SCARV_COP_INSN_W-1:0] enc,
    input logic [SCARV_COP_XLEN-1:0]   rs1
  );
    scarv_cop_entry_t e;
    e.enc = enc;
    e.rs1 = rs1;
    return e;
  endfunction

endpackage

// File: rtl/scarv_cop_fifo_ptr.sv
// -----------------------------------------------------------------------------
// scarv_cop_fifo_ptr
//   Read/write pointers and occupancy for a power-of-two FIFO. Pointers wrap
//   naturally; full/empty come from the occupancy count so no extra wrap bit
//   is needed on the pointers.
//
//   g_clk    in   core clock
//   g_reset  in   synchronous active-high reset, overrides everything
//   push     in   write one entry at wr_ptr (ignored when full)
//   pop      in   release the entry at rd_ptr (ignored when empty)
//   clr      in   discard all entries; push/pop ignored that cycle
//   rd_ptr   out  index of the oldest entry
//   wr_ptr   out  index of the next free slot
//   count    out  entries held, 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0
// -----------------------------------------------------------------------------
module scarv_cop_fifo_ptr
  import scarv_cop_pkg::*;
#(
  parameter int DEPTH = SCARV_COP_IFIFO_DEPTH
) (
  input  logic                     g_clk,
  input  logic                     g_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_ptr = rd_q;
  assign wr_ptr = wr_q;
  assign count  = cnt_q;

endmodule

// File: rtl/scarv_cop_ififo.sv
// -----------------------------------------------------------------------------
// scarv_cop_ififo
//   Instruction intake buffer in front of the COP decoder. Instructions and
//   their rs1 operand arrive from the host CPU over req/ack, are held in
//   order, and the oldest is offered to the decoder over valid/ready. A
//   counter of dispatched-but-uncompleted instructions closes the dispatch
//   window at MAX_INFLIGHT. Encodings pass through unmodified.
//
//   g_clk         in   core clock
//   g_reset       in   synchronous active-high reset; forces all outputs to 0
//   cpu_insn_req  in   CPU offers an instruction
//   cpu_insn_ack  out  instruction accepted this cycle (!full && !flush)
//   cpu_insn_enc  in   instruction encoding
//   cpu_rs1       in   rs1 value captured with the instruction
//   flush         in   discard all buffered, not yet dispatched entries
//   id_valid      out  head entry is dispatchable
//   id_ready      in   decoder takes the head entry
//   id_encoded    out  head encoding (0 when empty)
//   id_rs1        out  head rs1 value (0 when empty)
//   ex_done       in   one dispatched instruction completed (pulse)
//   fifo_count    out  entries held, 0..DEPTH
//   inflight      out  dispatched, uncompleted instructions
// -----------------------------------------------------------------------------
module scarv_cop_ififo
  import scarv_cop_pkg::*;
#(
  parameter int DEPTH        = SCARV_COP_IFIFO_DEPTH,
  parameter int MAX_INFLIGHT = SCARV_COP_MAX_INFLIGHT
) (
  input  logic                              g_clk,
  input  logic                              g_reset,
  input  logic                              cpu_insn_req,
  output logic                              cpu_insn_ack,
  input  logic [SCARV_COP_INSN_W-1:0]       cpu_insn_enc,
  input  logic [SCARV_COP_XLEN-1:0]         cpu_rs1,
  input  logic                              flush,
  output logic                              id_valid,
  input  logic                              id_ready,
  output logic [SCARV_COP_INSN_W-1:0]       id_encoded,
  output logic [SCARV_COP_XLEN-1:0]         id_rs1,
  input  logic                              ex_done,
  output logic [$clog2(DEPTH):0]            fifo_count,
  output logic [SCARV_COP_INFLIGHT_W-1:0]   inflight
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int IF_W  = SCARV_COP_INFLIGHT_W;
  localparam logic [IF_W-1:0] MAX_IF = IF_W'(MAX_INFLIGHT);

  scarv_cop_entry_t mem_q [DEPTH];
  scarv_cop_entry_t head;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             can_issue;

  logic [IF_W-1:0]  inflight_q;
  logic [IF_W-1:0]  inflight_d;

  // Intake side never looks at id_ready, so there is no ready->ack path.
  // Reset gates the combinational outputs so everything reads 0 during the
  // reset cycle regardless of the registered state.
  assign cpu_insn_ack = !g_reset && !full && !flush;
  assign push         = cpu_insn_req && cpu_insn_ack;

  assign can_issue = (inflight_q < MAX_IF);
  assign id_valid  = !g_reset && !empty && can_issue && !flush;
  assign pop       = id_valid && id_ready;

  scarv_cop_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .push    (push),
    .pop     (pop),
    .clr     (flush),
    .rd_ptr  (rd_ptr),
    .wr_ptr  (wr_ptr),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Written only at wr_ptr, which never aliases rd_ptr while the FIFO is
  // non-empty and accepting, so the head stays stable until it is popped.
  // Storage needs no reset: the head is masked to 0 whenever empty.
  always_ff @(posedge g_clk) begin
    if (push) begin
      mem_q[wr_ptr] <= scarv_cop_mk_entry(cpu_insn_enc, cpu_rs1);
    end
  end

  assign head       = mem_q[rd_ptr];
  assign id_encoded = (!g_reset && !empty) ? head.enc : '0;
  assign id_rs1     = (!g_reset && !empty) ? head.rs1 : '0;

  // Dispatch adds one, completion removes one. Flush leaves the count alone
  // because already-dispatched instructions still report ex_done.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({pop, ex_done})
      2'b10: inflight_d = inflight_q + 1'b1;
      2'b01: begin
        if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
      end
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign fifo_count = g_reset ? '0 : count;
  assign inflight   = g_reset ? '0 : inflight_q;

  // A completion with nothing outstanding means the execute stage and this
  // buffer disagree about what was dispatched.
  a_ex_done_underflow : assert property (
    @(posedge g_clk) disable iff (g_reset) !(ex_done && (inflight_q == '0))
  );

endmodule

// File: tb/tb_scarv_cop_ififo.sv
module tb_scarv_cop_ififo;

  localparam int DEPTH = 4;
  localparam int MAXI  = 2;

  logic        g_clk;
  logic        g_reset;
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_encoded;
  logic [31:0] id_rs1;
  logic        ex_done;
  logic [2:0]  fifo_count;
  logic [3:0]  inflight;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of buffered {enc,rs1} and a plain
  // integer count of outstanding dispatches.
  logic [63:0] q[$];
  int          m_infl = 0;

  scarv_cop_ififo #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .g_clk        (g_clk),
    .g_reset      (g_reset),
    .cpu_insn_req (cpu_insn_req),
    .cpu_insn_ack (cpu_insn_ack),
    .cpu_insn_enc (cpu_insn_enc),
    .cpu_rs1      (cpu_rs1),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_encoded   (id_encoded),
    .id_rs1       (id_rs1),
    .ex_done      (ex_done),
    .fifo_count   (fifo_count),
    .inflight     (inflight)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic m_ack();
    return !g_reset && (q.size() < DEPTH) && !flush;
  endfunction

  function automatic logic m_valid();
    return !g_reset && (q.size() > 0) && (m_infl < MAXI) && !flush;
  endfunction

  function automatic logic [63:0] m_head();
    if (g_reset || q.size() == 0) return 64'd0;
    return q[0];
  endfunction

  function automatic logic [2:0] m_count();
    return g_reset ? 3'd0 : 3'(q.size());
  endfunction

  function automatic logic [3:0] m_inflight();
    return g_reset ? 4'd0 : 4'(m_infl);
  endfunction

  // Apply inputs shortly after an edge and let combinational outputs settle.
  task automatic drive(input logic req, input logic [31:0] enc, input logic [31:0] rs1,
                       input logic rdy, input logic dn, input logic fl, input logic rst);
    cpu_insn_req = req;
    cpu_insn_enc = enc;
    cpu_rs1      = rs1;
    id_ready     = rdy;
    ex_done      = dn;
    flush        = fl;
    g_reset      = rst;
    #2;
  endtask

  // Advance the model by the rules for the current inputs, then the clock.
  task automatic step();
    logic deq, enq, dn;
    deq = m_valid() && id_ready;
    enq = cpu_insn_req && m_ack();
    dn  = ex_done && (m_infl > 0);
    if (g_reset) begin
      q.delete();
      m_infl = 0;
    end else begin
      if (flush) begin
        q.delete();
      end else begin
        if (deq) void'(q.pop_front());
        if (enq) q.push_back({cpu_insn_enc, cpu_rs1});
      end
      m_infl = m_infl + int'(deq) - int'(dn);
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (cpu_insn_ack !== 1'b1) begin
        bad++;
        $display("FAIL push_ack entry %0d got %b want 1", i, cpu_insn_ack);
      end
      step();
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hDEAD_BEEF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if ({cpu_insn_ack, id_valid, id_encoded, id_rs1} !== 66'd0) begin
      bad++;
      $display("FAIL reset_outs got ack=%b vld=%b enc=%h rs1=%h want all 0",
               cpu_insn_ack, id_valid, id_encoded, id_rs1);
    end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd0 || inflight !== 4'd0 || id_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got cnt=%0d infl=%0d vld=%b want 0 0 0",
               fifo_count, inflight, id_valid);
    end
    total++;
    if (cpu_insn_ack !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ack got %b want 1", cpu_insn_ack);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 32'h0000_302B, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (cpu_insn_ack !== 1'b1 || id_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_accept got ack=%b vld=%b want ack=1 vld=0", cpu_insn_ack, id_valid);
    end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (id_valid !== 1'b1 || id_encoded !== 32'h0000_302B || id_rs1 !== 32'h1234_5678
        || fifo_count !== 3'd1) begin
      bad++;
      $display("FAIL single_head got vld=%b enc=%h rs1=%h cnt=%0d want 1 0000302b 12345678 1",
               id_valid, id_encoded, id_rs1, fifo_count);
    end
  endtask

  task automatic test_fill_and_wrap();
    int n;
    do_reset();
    push_n(DEPTH);
    drive(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd4 || cpu_insn_ack !== 1'b0) begin
      bad++;
      $display("FAIL full_state got cnt=%0d ack=%b want 4 0", fifo_count, cpu_insn_ack);
    end
    step();
    drive(1'b1, $urandom(), $urandom(), 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (cpu_insn_ack !== 1'b0 || id_valid !== 1'b1 || {id_encoded, id_rs1} !== m_head()) begin
      bad++;
      $display("FAIL full_req_ready got ack=%b vld=%b head=%h want 0 1 %h",
               cpu_insn_ack, id_valid, {id_encoded, id_rs1}, m_head());
    end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd3) begin
      bad++;
      $display("FAIL full_deq_only got cnt=%0d want 3", fifo_count);
    end
    push_n(1);
    n = 0;
    while (q.size() > 0 && n < 20) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, (m_infl > 0), 1'b0, 1'b0);
      total++;
      if (id_valid !== m_valid() || {id_encoded, id_rs1} !== m_head()) begin
        bad++;
        $display("FAIL drain_order step %0d got vld=%b head=%h want %b %h",
                 n, id_valid, {id_encoded, id_rs1}, m_valid(), m_head());
      end
      step();
      n++;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd0 || n >= 20) begin
      bad++;
      $display("FAIL drain_done got cnt=%0d steps=%0d want 0 and <20", fifo_count, n);
    end
  endtask

  task automatic test_inflight_limit();
    do_reset();
    push_n(3);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (id_valid !== 1'b1) begin
        bad++;
        $display("FAIL window_dispatch %0d got vld=%b want 1", i, id_valid);
      end
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (id_valid !== 1'b0 || fifo_count !== 3'd1 || inflight !== 4'd2) begin
      bad++;
      $display("FAIL window_closed got vld=%b cnt=%0d infl=%0d want 0 1 2",
               id_valid, fifo_count, inflight);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (id_valid !== 1'b1 || inflight !== 4'd1) begin
      bad++;
      $display("FAIL window_reopen got vld=%b infl=%0d want 1 1", id_valid, inflight);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_n(3);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, $urandom(), $urandom(), 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (cpu_insn_ack !== 1'b1 || id_valid !== 1'b1 || fifo_count !== 3'd2 || inflight !== 4'd1) begin
      bad++;
      $display("FAIL b2b_pre got ack=%b vld=%b cnt=%0d infl=%0d want 1 1 2 1",
               cpu_insn_ack, id_valid, fifo_count, inflight);
    end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd2 || inflight !== 4'd1 || {id_encoded, id_rs1} !== m_head()) begin
      bad++;
      $display("FAIL b2b_post got cnt=%0d infl=%0d head=%h want 2 1 %h",
               fifo_count, inflight, {id_encoded, id_rs1}, m_head());
    end
  endtask

  task automatic test_flush();
    do_reset();
    push_n(4);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, $urandom(), $urandom(), 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (cpu_insn_ack !== 1'b0 || id_valid !== 1'b0 || fifo_count !== 3'd3) begin
      bad++;
      $display("FAIL flush_cycle got ack=%b vld=%b cnt=%0d want 0 0 3",
               cpu_insn_ack, id_valid, fifo_count);
    end
    step();
    drive(1'b1, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd0 || inflight !== 4'd1 || id_valid !== 1'b0 || cpu_insn_ack !== 1'b1) begin
      bad++;
      $display("FAIL flush_after got cnt=%0d infl=%0d vld=%b ack=%b want 0 1 0 1",
               fifo_count, inflight, id_valid, cpu_insn_ack);
    end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd1 || id_valid !== 1'b1 || id_encoded !== 32'hCAFE_0001
        || id_rs1 !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL flush_refill got cnt=%0d vld=%b enc=%h rs1=%h want 1 1 cafe0001 0badf00d",
               fifo_count, id_valid, id_encoded, id_rs1);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    push_n(3);
    drive(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({cpu_insn_ack, id_valid, id_encoded, id_rs1, fifo_count, inflight} !== 73'd0) begin
      bad++;
      $display("FAIL midrst_outs got ack=%b vld=%b enc=%h rs1=%h cnt=%0d infl=%0d want all 0",
               cpu_insn_ack, id_valid, id_encoded, id_rs1, fifo_count, inflight);
    end
    step();
    drive(1'b1, 32'h5555_AAAA, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd0 || cpu_insn_ack !== 1'b1 || id_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after got cnt=%0d ack=%b vld=%b want 0 1 0",
               fifo_count, cpu_insn_ack, id_valid);
    end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_count !== 3'd1 || {id_encoded, id_rs1} !== 64'h5555_AAAA_0F0F_F0F0) begin
      bad++;
      $display("FAIL midrst_resume got cnt=%0d head=%h want 1 5555aaaa0f0ff0f0",
               fifo_count, {id_encoded, id_rs1});
    end
  endtask

  task automatic test_random();
    logic fl, dn;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fl = ($urandom_range(31) == 0);
      dn = (m_infl > 0) && ($urandom_range(2) == 0);
      drive($urandom_range(1), $urandom(), $urandom(), $urandom_range(1), dn, fl, 1'b0);
      total++;
      if (cpu_insn_ack !== m_ack()) begin
        bad++;
        $display("FAIL rnd_ack cycle %0d got %b want %b", c, cpu_insn_ack, m_ack());
      end
      total++;
      if (id_valid !== m_valid()) begin
        bad++;
        $display("FAIL rnd_valid cycle %0d got %b want %b", c, id_valid, m_valid());
      end
      total++;
      if ({id_encoded, id_rs1} !== m_head()) begin
        bad++;
        $display("FAIL rnd_head cycle %0d got %h want %h", c, {id_encoded, id_rs1}, m_head());
      end
      total++;
      if (fifo_count !== m_count() || inflight !== m_inflight()) begin
        bad++;
        $display("FAIL rnd_counts cycle %0d got cnt=%0d infl=%0d want %0d %0d",
                 c, fifo_count, inflight, m_count(), m_inflight());
      end
      step();
    end
  endtask

  initial begin
    g_reset      = 1'b1;
    cpu_insn_req = 1'b0;
    cpu_insn_enc = '0;
    cpu_rs1      = '0;
    flush        = 1'b0;
    id_ready     = 1'b0;
    ex_done      = 1'b0;
    @(posedge g_clk);
    #1;
    test_reset();
    test_single();
    test_fill_and_wrap();
    test_inflight_limit();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
